// File: rtl/sig_debounce_pkg.sv
// sig_debounce_pkg: shared definitions for the three-channel input debouncer.
//   deb_state_e : per-channel debounce state (bit 1 of the encoding is the
//                 debounced level, so the level output is a direct flop bit)
//   DEB_CNT_DEF : default number of consecutive cycles a new level must hold
//   NUM_CH      : number of debounced channels
package sig_debounce_pkg;

    typedef enum logic [1:0] {
        ST_LO  = 2'b00,
        CHK_HI = 2'b01,
        ST_HI  = 2'b10,
        CHK_LO = 2'b11
    } deb_state_e;

    localparam int DEB_CNT_DEF = 16;
    localparam int NUM_CH      = 3;

endpackage

// File: rtl/deb_chan.sv
// deb_chan: one debounce channel -- 2-flop synchroniser, 4-state FSM, counter.
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   raw     : unsynchronised, possibly bouncing input
//   level   : debounced level (1 in ST_HI / CHK_LO)
//   rise    : one-cycle pulse on the edge the level is accepted 0->1
module deb_chan
    import sig_debounce_pkg::*;
#(
    parameter int DEB_CNT = DEB_CNT_DEF,
    parameter int CNT_W   = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CNT - 1);

    logic             s1_q, s2_q;
    deb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rise_q, rise_d;

    // Synchroniser: raw only ever reaches s1_q.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= raw;
            s2_q <= s1_q;
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_LO;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
        end
    end

    // Next state. The counter is cleared on every exit from a CHK state, so
    // it tops out at CNT_LAST and cannot wrap.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        rise_d  = 1'b0;
        case (state_q)
            ST_LO: begin
                if (s2_q) begin
                    state_d = CHK_HI;
                    cnt_d   = CNT_ONE;
                end
            end
            CHK_HI: begin
                if (!s2_q) begin
                    state_d = ST_LO;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_HI;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_HI: begin
                if (!s2_q) begin
                    state_d = CHK_LO;
                    cnt_d   = CNT_ONE;
                end
            end
            CHK_LO: begin
                if (s2_q) begin
                    state_d = ST_HI;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_LO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = ST_LO;
        endcase
    end

    // Outputs come straight from flops, so they are glitch-free.
    always_comb begin
        level = (state_q == ST_HI) || (state_q == CHK_LO);
        rise  = rise_q;
    end

endmodule

// File: rtl/sig_debounce.sv
// sig_debounce: three independent debounce channels feeding the control FSM.
//   clk       : system clock
//   reset_n   : asynchronous active-low reset
//   raw_in    : raw inputs, bit0->sig1, bit1->sig2, bit2->sig3
//   sig1..3   : debounced levels
//   rise      : per-channel one-cycle rising-edge strobes
module sig_debounce
    import sig_debounce_pkg::*;
#(
    parameter int DEB_CNT = DEB_CNT_DEF,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NUM_CH-1:0] raw_in,
    output logic              sig1,
    output logic              sig2,
    output logic              sig3,
    output logic [NUM_CH-1:0] rise
);

    logic [NUM_CH-1:0] level;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        deb_chan #(
            .DEB_CNT (DEB_CNT),
            .CNT_W   (CNT_W)
        ) u_chan (
            .clk     (clk),
            .reset_n (reset_n),
            .raw     (raw_in[g]),
            .level   (level[g]),
            .rise    (rise[g])
        );
    end

    assign sig1 = level[0];
    assign sig2 = level[1];
    assign sig3 = level[2];

endmodule

// File: tb/tb_sig_debounce.sv
module tb_sig_debounce;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [2:0] raw_in = 3'b111;

    logic       a_sig1, a_sig2, a_sig3, b_sig1, b_sig2, b_sig3;
    logic [2:0] a_rise, b_rise;

    always #5 clk = ~clk;

    // a: default DEB_CNT=16, b: minimum DEB_CNT=2
    sig_debounce #(.DEB_CNT(16), .CNT_W(16)) dut_a (
        .clk(clk), .reset_n(reset_n), .raw_in(raw_in),
        .sig1(a_sig1), .sig2(a_sig2), .sig3(a_sig3), .rise(a_rise));

    sig_debounce #(.DEB_CNT(2), .CNT_W(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .raw_in(raw_in),
        .sig1(b_sig1), .sig2(b_sig2), .sig3(b_sig3), .rise(b_rise));

    typedef struct packed {
        logic [2:0] lvl;
        logic [2:0] rise;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: a level flips once the last D samples seen by the
    // debouncer (raw delayed two clocks) all disagree with the current level.
    int          dv[2] = '{16, 2};
    bit          m_s1[2][3];
    bit          m_s2[2][3];
    bit          m_lvl[2][3];
    logic [31:0] m_hist[2][3];
    int          m_n[2][3];

    task automatic model_clear();
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < 3; c++) begin
                m_s1[d][c] = 0; m_s2[d][c] = 0; m_lvl[d][c] = 0;
                m_hist[d][c] = '0; m_n[d][c] = 0;
            end
    endtask

    task automatic model_step(input int d, output exp_t e);
        logic [31:0] mask;
        bit samp;
        e = '0;
        mask = (32'h1 << dv[d]) - 32'h1;
        for (int c = 0; c < 3; c++) begin
            samp = m_s2[d][c];
            m_s2[d][c] = m_s1[d][c];
            m_s1[d][c] = raw_in[c];
            m_hist[d][c] = {m_hist[d][c][30:0], samp};
            if (m_n[d][c] < 32) m_n[d][c]++;
            if (m_n[d][c] >= dv[d] &&
                (m_hist[d][c] & mask) == (m_lvl[d][c] ? 32'h0 : mask)) begin
                m_lvl[d][c] = !m_lvl[d][c];
                if (m_lvl[d][c]) e.rise[c] = 1'b1;
            end
            e.lvl[c] = m_lvl[d][c];
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        if (!reset_n) begin
            model_clear();
        end else begin
            model_step(0, e); q_a.push_back(e);
            model_step(1, e); q_b.push_back(e);
        end
    end

    task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @%0t: got lvl/rise=%b required %b", name, $time, act, exp);
    endtask

    // Monitor: every falling edge, compare both DUTs against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            chk("reset_a", {a_sig3, a_sig2, a_sig1, a_rise}, 6'b0);
            chk("reset_b", {b_sig3, b_sig2, b_sig1, b_rise}, 6'b0);
            q_a.delete();
            q_b.delete();
        end else begin
            if (q_a.size() == 0) chk("underflow_a", 6'b1, 6'b0);
            else begin
                e = q_a.pop_front();
                chk("deb16", {a_sig3, a_sig2, a_sig1, a_rise}, e);
            end
            if (q_b.size() == 0) chk("underflow_b", 6'b1, 6'b0);
            else begin
                e = q_b.pop_front();
                chk("deb2", {b_sig3, b_sig2, b_sig1, b_rise}, e);
            end
        end
    end

    // Hold raw_in at v for exactly n clock cycles.
    task automatic hold(input logic [2:0] v, input int n);
        @(negedge clk);
        #1 raw_in = v;
        repeat (n - 1) @(negedge clk);
    endtask

    // Assert reset mid-cycle, check outputs clear without a clock edge.
    task automatic async_reset(input int cycles);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_a", {a_sig3, a_sig2, a_sig1, a_rise}, 6'b0);
        chk("async_rst_b", {b_sig3, b_sig2, b_sig1, b_rise}, 6'b0);
        repeat (cycles) @(negedge clk);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        // Reset held with all inputs high, including a mid-cycle look.
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        chk("rst_hold_a", {a_sig3, a_sig2, a_sig1, a_rise}, 6'b0);
        @(negedge clk);
        #1 reset_n = 1'b1;
        hold(3'b111, 25);   // all three rise together
        hold(3'b000, 25);
        // Clean rise on ch0
        hold(3'b001, 25);
        // Glitch rejection on ch1
        hold(3'b011, 10);
        hold(3'b001, 20);
        hold(3'b011, 15);
        hold(3'b001, 1);
        hold(3'b011, 16);
        hold(3'b011, 10);
        // Clean fall on ch2, with a short low bounce first
        hold(3'b111, 25);
        hold(3'b011, 5);
        hold(3'b111, 20);
        hold(3'b011, 25);
        // Reset while ch0 is mid-check, and again while outputs are high
        hold(3'b000, 25);
        hold(3'b001, 10);
        async_reset(2);
        hold(3'b001, 25);
        hold(3'b111, 25);
        async_reset(2);
        hold(3'b111, 25);
        // Short pulses around the DEB_CNT=2 threshold
        hold(3'b000, 5);
        hold(3'b111, 1);
        hold(3'b000, 5);
        hold(3'b111, 2);
        hold(3'b000, 5);
        hold(3'b111, 3);
        hold(3'b000, 1);
        hold(3'b111, 5);
        // Random bouncing, mixing short glitches and long holds
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0)
                hold(3'($urandom), int'($urandom_range(1, 3)));
            else
                hold(3'($urandom), int'($urandom_range(1, 24)));
        end
        hold(3'b000, 25);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
